// File: rtl/merged_unpermutation_pkg.sv
// merged_unpermutation_pkg: FSM states, frame geometry and forward permutation tables P_s.
package merged_unpermutation_pkg;

    localparam int SIZE  = 257;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(SIZE + 1);
    localparam int IW    = $clog2(SIZE);

    localparam int N0 = 257;
    localparam int N1 = 85;
    localparam int N2 = 85;

    localparam int LO_END1   = 80;
    localparam int HI_START1 = 252;
    localparam int LO_END2   = 68;
    localparam int HI_START2 = 240;

    typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

    function automatic int frame_len(input logic [1:0] s);
        return s == 2'd1 ? N1 : s == 2'd2 ? N2 : N0;
    endfunction

    function automatic int lo_end(input logic [1:0] s);
        return s == 2'd1 ? LO_END1 : s == 2'd2 ? LO_END2 : SIZE;
    endfunction

    function automatic int hi_start(input logic [1:0] s);
        return s == 2'd1 ? HI_START1 : s == 2'd2 ? HI_START2 : SIZE;
    endfunction

    function automatic int active_pos(input logic [1:0] s, input int k);
        return k < lo_end(s) ? k : k - lo_end(s) + hi_start(s);
    endfunction

    // s=0 reverses the middle and swaps the ends; s=1/2 pack active positions into 0..N-1
    // and push the inactive gap above them.
    function automatic logic [SIZE-1:0][IW-1:0] gen_perm(input logic [1:0] s);
        logic [SIZE-1:0][IW-1:0] t;
        int k, v;
        t = '0;
        for (int j = 0; j < SIZE; j++) begin
            k = j < lo_end(s) ? j : j - hi_start(s) + lo_end(s);
            if (s == 2'd0)
                v = j == 0 ? 1 : j == SIZE - 1 ? 0 : SIZE - j;
            else if (j >= lo_end(s) && j < hi_start(s))
                v = j - lo_end(s) + frame_len(s);
            else
                v = s == 2'd1 ? (k + 35) % N1 : (2 * k + 7) % N2;
            t[j] = IW'(v);
        end
        return t;
    endfunction

    localparam logic [SIZE-1:0][IW-1:0] P0 = gen_perm(2'd0);
    localparam logic [SIZE-1:0][IW-1:0] P1 = gen_perm(2'd1);
    localparam logic [SIZE-1:0][IW-1:0] P2 = gen_perm(2'd2);

endpackage

// File: rtl/merged_unperm_dest_rom.sv
// merged_unperm_dest_rom: destination index D_s(k) = P_s(pos_s(k)) for beat k, tabulated at elaboration.
module merged_unperm_dest_rom
    import merged_unpermutation_pkg::*;
(
    input  logic [1:0]    sel_i,
    input  logic [CW-1:0] k_i,
    output logic [IW-1:0] dest_o
);

    function automatic logic [3:0][SIZE-1:0][IW-1:0] build_dest();
        logic [3:0][SIZE-1:0][IW-1:0] t;
        int p;
        t = '0;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < SIZE; k++) begin
                if (k < frame_len(2'(s))) begin
                    p = active_pos(2'(s), k);
                    case (s)
                        0:       t[s][k] = P0[p];
                        1:       t[s][k] = P1[p];
                        2:       t[s][k] = P2[p];
                        default: t[s][k] = IW'(k);
                    endcase
                end
            end
        end
        return t;
    endfunction

    localparam logic [3:0][SIZE-1:0][IW-1:0] D_TAB = build_dest();

    assign dest_o = D_TAB[sel_i][k_i];

endmodule

// File: rtl/merged_unpermutation.sv
// merged_unpermutation: collects a forward-permuted vector beat by beat and rebuilds the original order.
// Define MERGED_UNPERM_IDENTITY_EN to accept perm_select=3 as an identity frame instead of rejecting it.
module merged_unpermutation
    import merged_unpermutation_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 perm_select,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIZE-1:0][WIDTH-1:0] out_list,
    output logic                       err
);

    state_t                     state_q, state_d;
    logic [1:0]                 sel_q;
    logic [CW-1:0]              cnt_q;
    logic [SIZE-1:0][WIDTH-1:0] list_q;
    logic                       err_q;
    logic [IW-1:0]              dest;
    logic                       legal_sel, start_ok, reject, accept, last, drain;

`ifdef MERGED_UNPERM_IDENTITY_EN
    assign legal_sel = 1'b1;
`else
    assign legal_sel = perm_select != 2'd3;
`endif

    merged_unperm_dest_rom u_rom (
        .sel_i  (sel_q),
        .k_i    (cnt_q),
        .dest_o (dest)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_ok ? LOAD : IDLE;
            LOAD:    state_d = last ? FULL : LOAD;
            FULL:    state_d = drain ? IDLE : FULL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == LOAD;
        out_valid = state_q == FULL;
        accept    = in_ready && in_valid;
        last      = accept && cnt_q == CW'(frame_len(sel_q) - 1);
        drain     = out_valid && out_ready;
        start_ok  = state_q == IDLE && start && legal_sel;
        reject    = state_q == IDLE && start && !legal_sel;
    end

    // Starting a frame wipes the vector so untargeted entries read zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 2'd0;
            cnt_q  <= '0;
            list_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= reject;
            if (start_ok) begin
                sel_q  <= perm_select;
                cnt_q  <= '0;
                list_q <= '0;
            end else if (accept) begin
                cnt_q        <= cnt_q + 1'b1;
                list_q[dest] <= in_data;
            end
        end
    end

    assign out_list = list_q;
    assign err      = err_q;

endmodule

// File: tb/tb_merged_unpermutation.sv
// tb_merged_unpermutation: randomized frames checked against a position/table model of the unpermutation.
module tb_merged_unpermutation;
    import merged_unpermutation_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       start = 1'b0;
    logic [1:0]                 perm_select = 2'd0;
    logic                       in_valid = 1'b0;
    logic [WIDTH-1:0]           in_data = '0;
    logic                       out_ready = 1'b0;
    logic                       in_ready, out_valid, err;
    logic [SIZE-1:0][WIDTH-1:0] out_list;

    logic [WIDTH-1:0] beats    [SIZE];
    logic [WIDTH-1:0] exp_list [SIZE];
    int checks = 0;
    int errors = 0;
    int err_cnt = 0;

    merged_unpermutation dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .perm_select (perm_select),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_list    (out_list),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err === 1'b1) err_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int tb_len(input int s);
        return (s == 1 || s == 2) ? 85 : 257;
    endfunction

    // Beat k -> forward position: low run, then the high tail.
    function automatic int tb_pos(input int s, input int k);
        if (s == 1) return k < 80 ? k : k + 172;
        if (s == 2) return k < 68 ? k : k + 172;
        return k;
    endfunction

    function automatic int ptab(input int s, input int p);
        case (s)
            0:       return int'(P0[p]);
            1:       return int'(P1[p]);
            2:       return int'(P2[p]);
            default: return p;
        endcase
    endfunction

    // x[P_s(pos)] = y[k]; everything else zero.
    function automatic void build_expected(input int s, input int nb);
        for (int i = 0; i < SIZE; i++) exp_list[i] = '0;
        for (int k = 0; k < nb; k++) exp_list[ptab(s, tb_pos(s, k))] = beats[k];
    endfunction

    function automatic int diff_count(output int first);
        int n;
        n = 0;
        first = 0;
        for (int i = SIZE - 1; i >= 0; i--)
            if (out_list[i] !== exp_list[i]) begin
                first = i;
                n++;
            end
        return n;
    endfunction

    function automatic int nonzero(input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) if (out_list[i] !== '0) n++;
        return n;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < SIZE; k++) beats[k] = $urandom;
    endtask

    task automatic send_frame(input int s, input bit gaps, input int nb, input int poke);
        @(negedge clk);
        start = 1'b1;
        perm_select = 2'(s);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_start s=%0d: in_ready=%b expected 1", s, in_ready);
        end
        for (int k = 0; k < nb; k++) begin
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data = beats[k];
            if (k == poke) begin
                start = 1'b1;
                perm_select = 2'd3;
            end
            @(negedge clk);
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++;
        if (nonzero(0, SIZE - 1) != 0) begin
            errors++;
            $display("FAIL reset_out_list: %0d nonzero entries expected 0", nonzero(0, SIZE - 1));
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_select0();
        int hist [SIZE];
        int d, f, v, bad;
        for (int k = 0; k < SIZE; k++) beats[k] = WIDTH'(k + 'h100);
        send_frame(0, 1'b0, 257, -1);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL s0_out_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_list[1] !== 32'h100) begin errors++; $display("FAIL s0_list1: got %h expected 00000100", out_list[1]); end
        checks++;
        if (out_list[0] !== 32'h200) begin errors++; $display("FAIL s0_list0: got %h expected 00000200", out_list[0]); end
        checks++;
        if (out_list[256] !== 32'h101) begin errors++; $display("FAIL s0_list256: got %h expected 00000101", out_list[256]); end
        for (int i = 0; i < SIZE; i++) hist[i] = 0;
        for (int i = 0; i < SIZE; i++) begin
            v = int'(out_list[i]) - 'h100;
            if (v >= 0 && v < SIZE) hist[v]++;
        end
        bad = 0;
        for (int i = 0; i < SIZE; i++) if (hist[i] != 1) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL s0_coverage: %0d beats not placed exactly once, expected 0", bad); end
        build_expected(0, 257);
        d = diff_count(f);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL s0_model: %0d entries differ, first [%0d] got %h expected %h", d, f, out_list[f], exp_list[f]);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL s0_drain: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_select1();
        int d, f, e0;
        fill_random();
        beats[0] = 32'hAAAA0000;
        beats[84] = 32'h5555;
        e0 = err_cnt;
        send_frame(1, 1'b1, 85, 10);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL s1_out_valid: got %b expected 1", out_valid); end
        checks++;
        if (out_list[35] !== 32'hAAAA0000) begin errors++; $display("FAIL s1_list35: got %h expected aaaa0000", out_list[35]); end
        checks++;
        if (out_list[34] !== 32'h5555) begin errors++; $display("FAIL s1_list34: got %h expected 00005555", out_list[34]); end
        checks++;
        if (out_list[100] !== '0) begin errors++; $display("FAIL s1_list100: got %h expected 00000000", out_list[100]); end
        checks++;
        if (err_cnt != e0) begin errors++; $display("FAIL s1_load_start_err: %0d err pulses expected 0", err_cnt - e0); end
        build_expected(1, 85);
        d = diff_count(f);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL s1_model: %0d entries differ, first [%0d] got %h expected %h", d, f, out_list[f], exp_list[f]);
        end
        consume();
    endtask

    task automatic test_select2();
        int bad;
        fill_random();
        send_frame(2, 1'b1, 85, -1);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL s2_out_valid: got %b expected 1", out_valid); end
        bad = 0;
        for (int k = 0; k < 85; k++) if (out_list[ptab(2, tb_pos(2, k))] !== beats[k]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL s2_forward: %0d beats not recovered expected 0", bad); end
        checks++;
        if (nonzero(85, 256) != 0) begin
            errors++;
            $display("FAIL s2_upper_zero: %0d nonzero entries expected 0", nonzero(85, 256));
        end
        consume();
    endtask

    task automatic test_stall();
        int d, f, e0;
        fill_random();
        send_frame(0, 1'b1, 257, -1);
        build_expected(0, 257);
        e0 = err_cnt;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin start = 1'b1; perm_select = 2'd1; end
            if (c == 5) begin in_valid = 1'b1; in_data = 32'hDEADBEEF; end
            @(negedge clk);
            start = 1'b0;
            in_valid = 1'b0;
            d = diff_count(f);
            checks++;
            if (out_valid !== 1'b1 || d != 0) begin
                errors++;
                $display("FAIL stall_hold c=%0d: out_valid=%b diffs=%0d expected 1 and 0", c, out_valid, d);
            end
        end
        checks++;
        if (err_cnt != e0) begin errors++; $display("FAIL stall_full_start_err: %0d err pulses expected 0", err_cnt - e0); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        consume();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_midframe();
        int d, f;
        fill_random();
        send_frame(0, 1'b0, 40, -1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: in_ready=%b out_valid=%b err=%b expected 0 0 0", in_ready, out_valid, err);
        end
        checks++;
        if (nonzero(0, SIZE - 1) != 0) begin
            errors++;
            $display("FAIL midreset_list: %0d nonzero entries expected 0", nonzero(0, SIZE - 1));
        end
        @(negedge clk);
        rst_n = 1'b1;
        fill_random();
        send_frame(0, 1'b1, 257, -1);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_out_valid: got %b expected 1", out_valid); end
        build_expected(0, 257);
        d = diff_count(f);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL midreset_model: %0d entries differ, first [%0d] got %h expected %h", d, f, out_list[f], exp_list[f]);
        end
        consume();
    endtask

    task automatic test_select3();
        int d, f, e0;
        in_valid = 1'b1;
        in_data = 32'h12345678;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        d = diff_count(f);
        checks++;
        if (d != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_in_valid: diffs=%0d in_ready=%b expected 0 and 0", d, in_ready);
        end
`ifdef MERGED_UNPERM_IDENTITY_EN
        e0 = err_cnt;
        fill_random();
        send_frame(3, 1'b1, 257, -1);
        checks++;
        if (out_valid !== 1'b1 || err_cnt != e0) begin
            errors++;
            $display("FAIL s3_accept: out_valid=%b err pulses=%0d expected 1 and 0", out_valid, err_cnt - e0);
        end
        build_expected(3, 257);
        d = diff_count(f);
        checks++;
        if (d != 0) begin
            errors++;
            $display("FAIL s3_identity: %0d entries differ, first [%0d] got %h expected %h", d, f, out_list[f], exp_list[f]);
        end
        consume();
`else
        e0 = err_cnt;
        @(negedge clk);
        start = 1'b1;
        perm_select = 2'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL s3_reject: err=%b in_ready=%b expected 1 and 0", err, in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_cnt != e0 + 1) begin errors++; $display("FAIL s3_err_pulse: %0d err cycles expected 1", err_cnt - e0); end
        d = diff_count(f);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || d != 0) begin
            errors++;
            $display("FAIL s3_stay_idle: in_ready=%b out_valid=%b diffs=%0d expected 0 0 0", in_ready, out_valid, d);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_select0();
        test_select1();
        test_select2();
        test_stall();
        test_reset_midframe();
        test_select3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/merged_unpermutation.md
MERGED_UNPERMUTATION -- requirements
Module: merged_unpermutation

Interface
REQ-001 SIZE, 257, number of vector elements.
REQ-002 WIDTH, 32, bits per element.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin a frame.
REQ-006 perm_select  input  2  permutation index; sampled only when start is accepted.
REQ-007 in_valid  input  1  in_data carries a valid beat.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  WIDTH  one element of the forward-permuted vector.
REQ-010 out_valid  output  1  out_list holds a complete un-permuted vector.
REQ-011 out_ready  input  1  consumer takes out_list this cycle.
REQ-012 out_list  output  SIZE x WIDTH  registered reconstructed vector.
REQ-013 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-014 The forward map P_s is defined by out[j] = in[P_s(j)]; this block SHALL reconstruct x such that x[P_s(j)] = y[j].
REQ-015 Frame length N_s SHALL be 257 for s=0 and 85 for s=1 and s=2.
REQ-016 Beat k (0..N_s-1) SHALL correspond to the k-th active forward position in ascending order: s=0 uses 0..256; s=1 uses 0..79 then 252..256; s=2 uses 0..67 then 240..256.
REQ-017 Beat k SHALL be written to out_list[D_s(k)], where D_s(k) = P_s(pos_s(k)) is read from the destination ROM.
REQ-018 The FSM SHALL have three states: IDLE, LOAD and FULL.
REQ-019 In IDLE, start with a legal perm_select SHALL latch the select, clear all out_list entries to zero, clear the beat counter and move to LOAD on the next cycle.
REQ-020 in_ready SHALL be 1 only in LOAD; a beat is accepted when in_valid and in_ready are both 1, and each accepted beat increments the counter.
REQ-021 Acceptance of beat N_s-1 SHALL move the FSM to FULL; out_valid SHALL be 1 on the cycle after that last accept.
REQ-022 In FULL, out_list SHALL hold stable; out_valid and out_ready both 1 SHALL return the FSM to IDLE, and out_valid SHALL drop the next cycle.
REQ-023 start in LOAD or FULL SHALL be ignored, with no err pulse.
REQ-024 in_valid in IDLE or FULL SHALL be ignored, and no write occurs.
REQ-025 For s=1 and s=2, out_list entries not targeted by any D_s(k) SHALL read zero.
REQ-026 perm_select=3 SHALL be handled per REQ-030/031.
REQ-027 Elements SHALL be moved as-is, with no arithmetic; the counter width SHALL be $clog2(SIZE+1).

Reset
REQ-028 When rst_n is low, the block SHALL enter IDLE and drive in_ready=0, out_valid=0, err=0, out_list all zero and counter=0, independent of clk.
REQ-029 Reset asserted during LOAD or FULL SHALL abort the frame with no partial output retained.

Configuration
REQ-030 With MERGED_UNPERM_IDENTITY_EN defined, perm_select=3 SHALL select an identity frame with N=257 and D(k)=k.
REQ-031 Without MERGED_UNPERM_IDENTITY_EN, start with perm_select=3 SHALL be rejected: the FSM stays in IDLE and err pulses for exactly one cycle.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the N_s constants, the active-position boundaries, and the three forward tables P_s as constant arrays.
REQ-033 One sub-module, merged_unperm_dest_rom, SHALL map (select, k) to D_s(k), computing the inverse from the package tables at elaboration.

Verification
REQ-034 Select 0: beat k carries k+0x100 -> out_list[1]=0x100, out_list[0]=0x200 (beat 256), out_list[256]=0x101; every D_0(k) is covered exactly once.
REQ-035 Select 1: beat 0 carries 0xAAAA0000 and beat 84 carries 0x5555 -> out_list[35]=0xAAAA0000, out_list[34]=0x5555, out_list[100]=0.
REQ-036 Select 2: random frame, then forward-permute the result -> equals the input stream; out_list[85..256] are zero.
REQ-037 Random in_valid gaps and out_ready held low for 10 cycles -> out_list stable and out_valid held; a start issued in FULL is ignored.
REQ-038 rst_n low at beat 40 of a select-0 frame -> all outputs zero immediately; the next frame completes correctly.
REQ-039 perm_select=3 -> err pulses once with the macro undefined; with the macro defined, out_list[k] equals beat k.
